data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the execute/memory stage and the byte-addressed data memory.
- The cache owns the memory port. It serves loads from its lines and passes every store through to memory in the same cycle.
- On a read miss it stalls the pipeline and refills the whole line from memory, one word per cycle.
- Sub-word load/store semantics (func3) are identical to the memory behind it.

---
 rtl/data_cache_pkg.sv | 45 ++++
 rtl/data_cache_load_ext.sv | 29 ++
 rtl/data_cache.sv | 169 ++++++++++++++++
 tb/tb_data_cache.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared types, func3 codes and address-split helpers for the direct-mapped data cache.
package data_cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [2:0] F3_B  = 3'h0;
    localparam logic [2:0] F3_H  = 3'h1;
    localparam logic [2:0] F3_W  = 3'h2;
    localparam logic [2:0] F3_BU = 3'h4;
    localparam logic [2:0] F3_HU = 3'h5;

    localparam int OFFSET_W = 2;

    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int addr_width, input int num_sets, input int line_words);
        return addr_width - OFFSET_W - $clog2(num_sets) - $clog2(line_words);
    endfunction

    // Unknown size codes are treated as aligned so stores fall back to a full-word write.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return ~off[0];
            F3_W:        return (off == 2'b00);
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic is_load_f3(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_cache_load_ext.sv
// Load extension: selects the byte/half/word at the offset and sign- or zero-extends it by func3.
module data_cache_load_ext
    import data_cache_pkg::*;
(
    input  logic [31:0] line_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = line_word[{offset, 3'b000} +: 8];
    assign half_sel = line_word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data = '0;
        case (func3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            F3_W:    data = line_word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache with whole-line refill on load miss.
// Optional hit/miss counters are built when DATA_CACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | serve hits, pass stores and misaligned loads to memory, detect load misses
// FILL  | refill one word per cycle from memory, pipeline stalled
module data_cache
    import data_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  write_enable,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  stall,
    output logic                  mem_write_enable,
    output logic [2:0]            mem_func3,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int WORD_W = word_bits(LINE_WORDS);
    localparam int IDX_W  = index_bits(NUM_SETS);
    localparam int TAG_W  = tag_bits(ADDR_WIDTH, NUM_SETS, LINE_WORDS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    state_t                state;
    logic [WORD_W-1:0]     fill_cnt;
    logic [DATA_WIDTH-1:0] data_arr [NUM_SETS*LINE_WORDS];
    logic [TAG_W-1:0]      tag_arr  [NUM_SETS];
    logic [NUM_SETS-1:0]   valid;

    logic [1:0]        req_off;
    logic [WORD_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;

    assign req_off  = address[1:0];
    assign req_word = address[OFFSET_W +: WORD_W];
    assign req_idx  = address[OFFSET_W+WORD_W +: IDX_W];
    assign req_tag  = address[ADDR_WIDTH-1 -: TAG_W];

    logic req_active, aligned, tag_hit, is_load, cached_load;
    logic load_hit, load_miss, store_hit, bypass_load;

    // rst gates the request so stall and data_out drop the moment reset asserts.
    assign req_active  = req_valid && !rst && (state == IDLE);
    assign aligned     = is_aligned(func3, req_off);
    assign tag_hit     = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign is_load     = req_active && !write_enable;
    assign cached_load = is_load && aligned && is_load_f3(func3);
    assign load_hit    = cached_load && tag_hit;
    assign load_miss   = cached_load && !tag_hit;
    assign store_hit   = req_active && write_enable && aligned && tag_hit;
    assign bypass_load = is_load && !aligned;

    logic [DATA_WIDTH-1:0] hit_word, ext_data, store_word;

    assign hit_word = data_arr[{req_idx, req_word}];

    data_cache_load_ext u_load_ext (
        .line_word (hit_word),
        .offset    (req_off),
        .func3     (func3),
        .data      (ext_data)
    );

    always_comb begin
        data_out = '0;
        if (load_hit)
            data_out = ext_data;
        else if (bypass_load)
            data_out = mem_read_data;
    end

    assign stall = (state == FILL) || load_miss;

    always_comb begin
        mem_write_enable = 1'b0;
        mem_func3        = F3_W;
        mem_address      = address;
        mem_write_data   = write_data;
        if (state == FILL) begin
            mem_address = {req_tag, req_idx, fill_cnt, 2'b00};
        end else if (req_valid) begin
            mem_write_enable = write_enable;
            mem_func3        = func3;
        end
    end

    always_comb begin
        store_word = hit_word;
        case (func3)
            F3_B:    store_word[{req_off, 3'b000} +: 8]     = write_data[7:0];
            F3_H:    store_word[{req_off[1], 4'b0000} +: 16] = write_data[15:0];
            default: store_word = write_data;
        endcase
    end

    // Data and tag storage carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            data_arr[{req_idx, fill_cnt}] <= mem_read_data;
            if (fill_cnt == LAST_WORD)
                tag_arr[req_idx] <= req_tag;
        end else if (store_hit) begin
            data_arr[{req_idx, req_word}] <= store_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fill_cnt <= '0;
            valid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_miss) begin
                        state    <= FILL;
                        fill_cnt <= '0;
                    end
                end
                FILL: begin
                    fill_cnt <= fill_cnt + WORD_W'(1);
                    if (fill_cnt == LAST_WORD) begin
                        valid[req_idx] <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (load_hit)
                hit_q <= hit_q + 32'd1;
            if (load_miss)
                miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: byte-addressed memory model, expected loads queued at issue.
module tb_data_cache;
    import data_cache_pkg::*;

`ifdef DATA_CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        write_enable;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] data_out;
    logic        stall;
    logic        mem_write_enable;
    logic [2:0]  mem_func3;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    data_cache dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .write_enable     (write_enable),
        .func3            (func3),
        .address          (address),
        .write_data       (write_data),
        .data_out         (data_out),
        .stall            (stall),
        .mem_write_enable (mem_write_enable),
        .mem_func3        (mem_func3),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    // Byte-addressed memory model with combinational read; preload port used during reset.
    logic [7:0]  mem [0:16383];
    logic [13:0] ma;
    logic [31:0] mw;
    logic        pl_en = 1'b0;
    logic [13:0] pl_addr;
    logic [31:0] pl_data;

    always_comb begin
        ma = mem_address[13:0];
        mw = {mem[ma+14'd3], mem[ma+14'd2], mem[ma+14'd1], mem[ma]};
        case (mem_func3)
            3'h0:    mem_read_data = {{24{mw[7]}}, mw[7:0]};
            3'h1:    mem_read_data = {{16{mw[15]}}, mw[15:0]};
            3'h2:    mem_read_data = mw;
            3'h4:    mem_read_data = {24'h0, mw[7:0]};
            3'h5:    mem_read_data = {16'h0, mw[15:0]};
            default: mem_read_data = '0;
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr]       <= pl_data[7:0];
            mem[pl_addr+14'd1] <= pl_data[15:8];
            mem[pl_addr+14'd2] <= pl_data[23:16];
            mem[pl_addr+14'd3] <= pl_data[31:24];
        end else if (mem_write_enable) begin
            mem[ma] <= mem_write_data[7:0];
            if (mem_func3 != 3'h0)
                mem[ma+14'd1] <= mem_write_data[15:8];
            if (mem_func3 != 3'h0 && mem_func3 != 3'h1) begin
                mem[ma+14'd2] <= mem_write_data[23:16];
                mem[ma+14'd3] <= mem_write_data[31:24];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] exp_data_q [$];
    logic [31:0] exp_addr_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        check_val({tag, "_hit_count"},  hit_count,  STATS ? 32'(exp_hits)   : 32'h0);
        check_val({tag, "_miss_count"}, miss_count, STATS ? 32'(exp_misses) : 32'h0);
    endtask

    // exp_fill: refill cycles expected (0 for hit/bypass); cached: aligned load that ends in a hit.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] exp, input int exp_fill, input bit cached);
        int n;
        logic [31:0] a;
        @(posedge clk); #1;
        req_valid    = 1'b1;
        write_enable = 1'b0;
        func3        = f3;
        address      = addr;
        write_data   = 32'h0;
        exp_data_q.push_back(exp);
        for (int i = 0; i < exp_fill; i++)
            exp_addr_q.push_back({addr[31:4], 4'h0} + 32'(4 * i));
        if (exp_fill > 0)
            exp_misses++;
        if (cached)
            exp_hits++;
        @(negedge clk);
        n = 0;
        while (stall && n < 20) begin
            if (n > 0) begin
                a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
                check_val({tag, "_fill_addr"}, mem_address, a);
            end
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        check_val({tag, "_stall_cycles"}, (n == 0) ? 32'h0 : 32'(n - 1), 32'(exp_fill));
        check_val({tag, "_leftover_fill"}, 32'(exp_addr_q.size()), 32'h0);
        exp_addr_q.delete();
        check_val({tag, "_data"}, data_out, exp_data_q.pop_front());
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] data);
        @(posedge clk); #1;
        req_valid    = 1'b1;
        write_enable = 1'b1;
        func3        = f3;
        address      = addr;
        write_data   = data;
        @(negedge clk);
        check_val({tag, "_mem_we"},    {31'h0, mem_write_enable}, 32'h1);
        check_val({tag, "_stall"},     {31'h0, stall},            32'h0);
        check_val({tag, "_mem_addr"},  mem_address,               addr);
        check_val({tag, "_mem_wdata"}, mem_write_data,            data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pl_a [12];
        logic [31:0] pl_d [12];
        pl_a[0]  = 32'h100;  pl_d[0]  = 32'h1122_3344;
        pl_a[1]  = 32'h104;  pl_d[1]  = 32'h5566_7788;
        pl_a[2]  = 32'h108;  pl_d[2]  = 32'h99AA_BBCC;
        pl_a[3]  = 32'h10C;  pl_d[3]  = 32'hDDEE_FF00;
        pl_a[4]  = 32'h2000; pl_d[4]  = 32'h0;
        pl_a[5]  = 32'h2004; pl_d[5]  = 32'h0;
        pl_a[6]  = 32'h2008; pl_d[6]  = 32'h0;
        pl_a[7]  = 32'h200C; pl_d[7]  = 32'h0;
        pl_a[8]  = 32'h300;  pl_d[8]  = 32'h0BAD_F00D;
        pl_a[9]  = 32'h304;  pl_d[9]  = 32'h1;
        pl_a[10] = 32'h308;  pl_d[10] = 32'h2;
        pl_a[11] = 32'h30C;  pl_d[11] = 32'h3;

        rst          = 1'b1;
        req_valid    = 1'b0;
        write_enable = 1'b0;
        func3        = 3'h2;
        address      = 32'h0;
        write_data   = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            pl_en   = 1'b1;
            pl_addr = pl_a[i][13:0];
            pl_data = pl_d[i];
        end
        @(posedge clk); #1;
        pl_en = 1'b0;
        @(negedge clk);
        check_val("rst_stall",    {31'h0, stall}, 32'h0);
        check_val("rst_data_out", data_out,       32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_mem_we",    {31'h0, mem_write_enable}, 32'h0);
        check_val("idle_mem_func3", {29'h0, mem_func3},        32'h2);
        check_val("idle_data_out",  data_out,                  32'h0);
        check_stats("reset");

        do_load("lw_100_miss", 32'h100, F3_W, 32'h1122_3344, 4, 1'b1);
        check_stats("after_miss");
        do_load("lb_10b",  32'h10B, F3_B,  32'hFFFF_FF99, 0, 1'b1);
        do_load("lbu_10b", 32'h10B, F3_BU, 32'h0000_0099, 0, 1'b1);
        do_load("lh_106",  32'h106, F3_H,  32'h0000_5566, 0, 1'b1);
        do_load("lhu_10e", 32'h10E, F3_HU, 32'h0000_DDEE, 0, 1'b1);
        check_stats("after_hits");

        do_store("sb_105", 32'h105, F3_B, 32'h0000_00AB);
        do_load("lw_104_merged", 32'h104, F3_W, 32'h5566_AB88, 0, 1'b1);

        do_store("sw_2000", 32'h2000, F3_W, 32'hCAFE_BABE);
        do_load("lw_2000_miss", 32'h2000, F3_W, 32'hCAFE_BABE, 4, 1'b1);
        check_stats("after_sw_lw");

        do_load("lw_102_bypass", 32'h102, F3_W, 32'hAB88_1122, 0, 1'b0);
        check_stats("after_bypass");

        // Reset asserted during the second refill cycle of a miss to 0x300.
        @(posedge clk); #1;
        req_valid    = 1'b1;
        write_enable = 1'b0;
        func3        = F3_W;
        address      = 32'h300;
        @(negedge clk);
        check_val("rstfill_miss_stall", {31'h0, stall}, 32'h1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
        #1;
        check_val("rstfill_stall", {31'h0, stall}, 32'h0);
        check_stats("rstfill");
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;

        do_load("relw_100_miss", 32'h100, F3_W, 32'h1122_3344, 4, 1'b1);
        do_load("relw_300_miss", 32'h300, F3_W, 32'h0BAD_F00D, 4, 1'b1);
        check_stats("final");

        @(posedge clk); #1;
        req_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
